// File: rtl/ram_arbiter_ctrl.sv
// Two-port round-robin arbiter and strobe sequencer for the single-port DFF RAM.
// Optional `RAM_INIT_CLEAR_EN: after reset, zero every RAM word before serving requests.
module ram_arbiter_ctrl #(
  parameter int ADDR_BITS = 4,
  parameter int DATA_BITS = 8,
  parameter int RAM_BYTES = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 p0_req,
  input  logic                 p0_we,
  input  logic [ADDR_BITS-1:0] p0_addr,
  input  logic [DATA_BITS-1:0] p0_wdata,
  output logic                 p0_ready,
  output logic                 p0_done,
  input  logic                 p1_req,
  input  logic                 p1_we,
  input  logic [ADDR_BITS-1:0] p1_addr,
  input  logic [DATA_BITS-1:0] p1_wdata,
  output logic                 p1_ready,
  output logic                 p1_done,
  output logic [DATA_BITS-1:0] rsp_rdata,
  output logic                 busy,
  output logic [ADDR_BITS-1:0] mem_mar,
  output logic [DATA_BITS-1:0] mem_data_in,
  input  logic [DATA_BITS-1:0] mem_data_out,
  output logic                 mem_ce_n,
  output logic                 mem_lr_n
);

`ifdef RAM_INIT_CLEAR_EN
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_RESP, S_INIT} state_e;
  localparam state_e RESET_STATE = S_INIT;
  localparam int CNT_BITS = $clog2(RAM_BYTES + 1);
  localparam logic [CNT_BITS-1:0] CNT_END = CNT_BITS'(RAM_BYTES);
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
`else
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_RESP} state_e;
  localparam state_e RESET_STATE = S_IDLE;
`endif

  state_e               state_q, state_d;
  logic                 last_grant_q, last_grant_d;
  logic                 port_q, port_d;
  logic                 we_q, we_d;
  logic [ADDR_BITS-1:0] mar_q, mar_d;
  logic [DATA_BITS-1:0] din_q, din_d;
  logic [DATA_BITS-1:0] rdata_q, rdata_d;
  logic                 ce_n_q, ce_n_d;
  logic                 lr_n_q, lr_n_d;
  logic                 grant;
  logic                 accept;

  // A lone requester always wins; on a tie the port that did not win last time goes.
  assign grant  = (p0_req && p1_req) ? ~last_grant_q : p1_req;
  assign accept = (state_q == S_IDLE) && (p0_req || p1_req);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; the comb blocks below use blocking assignments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RESET_STATE;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // NOTE: every comb output gets a default before the case, so no latches are inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (accept) state_d = S_ISSUE;
      S_ISSUE:   state_d = we_q ? S_RESP : S_CAPTURE;
      S_CAPTURE: state_d = S_RESP;
      S_RESP:    state_d = S_IDLE;
`ifdef RAM_INIT_CLEAR_EN
      S_INIT:    if (cnt_q == CNT_END) state_d = S_IDLE;
`endif
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    last_grant_d = last_grant_q;
    port_d       = port_q;
    we_d         = we_q;
    mar_d        = mar_q;
    din_d        = din_q;
    rdata_d      = rdata_q;
    ce_n_d       = 1'b1;
    lr_n_d       = 1'b1;
`ifdef RAM_INIT_CLEAR_EN
    cnt_d        = cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          port_d       = grant;
          last_grant_d = grant;
          we_d         = grant ? p1_we    : p0_we;
          mar_d        = grant ? p1_addr  : p0_addr;
          din_d        = grant ? p1_wdata : p0_wdata;
          lr_n_d       = ~(grant ? p1_we : p0_we);
          ce_n_d       =  (grant ? p1_we : p0_we);
        end
      end
      S_CAPTURE: rdata_d = mem_data_out;
`ifdef RAM_INIT_CLEAR_EN
      S_INIT: begin
        if (cnt_q != CNT_END) begin
          mar_d  = cnt_q[ADDR_BITS-1:0];
          din_d  = '0;
          lr_n_d = 1'b0;
          cnt_d  = cnt_q + 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      port_q  <= 1'b0;
      we_q    <= 1'b0;
      mar_q   <= '0;
      din_q   <= '0;
      rdata_q <= '0;
      ce_n_q  <= 1'b1;
      lr_n_q  <= 1'b1;
`ifdef RAM_INIT_CLEAR_EN
      cnt_q   <= '0;
`endif
    end else begin
      port_q  <= port_d;
      we_q    <= we_d;
      mar_q   <= mar_d;
      din_q   <= din_d;
      rdata_q <= rdata_d;
      ce_n_q  <= ce_n_d;
      lr_n_q  <= lr_n_d;
`ifdef RAM_INIT_CLEAR_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign p0_ready    = (state_q == S_IDLE) && !grant && p0_req;
  assign p1_ready    = (state_q == S_IDLE) &&  grant && p1_req;
  assign p0_done     = (state_q == S_RESP) && !port_q;
  assign p1_done     = (state_q == S_RESP) &&  port_q;
  assign busy        = (state_q != S_IDLE);
  assign rsp_rdata   = rdata_q;
  assign mem_mar     = mar_q;
  assign mem_data_in = din_q;
  assign mem_ce_n    = ce_n_q;
  assign mem_lr_n    = lr_n_q;

endmodule

// File: tb/tb_ram_arbiter_ctrl.sv
// Directed bench for ram_arbiter_ctrl with a behavioural DFF RAM attached to its memory port.
module tb_ram_arbiter_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
  logic [3:0] p0_addr = '0, p1_addr = '0;
  logic [7:0] p0_wdata = '0, p1_wdata = '0;
  logic       p0_ready, p0_done, p1_ready, p1_done, busy;
  logic [7:0] rsp_rdata, mem_data_in;
  logic [7:0] mem_data_out = '0;
  logic [3:0] mem_mar;
  logic       mem_ce_n, mem_lr_n;
  logic [7:0] ram [16];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_arbiter_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ready(p0_ready), .p0_done(p0_done),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ready(p1_ready), .p1_done(p1_done),
    .rsp_rdata(rsp_rdata), .busy(busy),
    .mem_mar(mem_mar), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .mem_ce_n(mem_ce_n), .mem_lr_n(mem_lr_n)
  );

  // NOTE: the RAM array has no reset; its contents survive rst_n like the real macro.
  always @(posedge clk) begin
    if (!mem_lr_n) ram[mem_mar] <= mem_data_in;
    if (!mem_ce_n) mem_data_out <= ram[mem_mar];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic rdy(input int p);
    return (p != 0) ? p1_ready : p0_ready;
  endfunction

  function automatic logic dn(input int p);
    return (p != 0) ? p1_done : p0_done;
  endfunction

  task automatic drive(input int p, input logic req, input logic we,
                       input logic [3:0] addr, input logic [7:0] wd);
    if (p != 0) begin
      p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wd;
    end else begin
      p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wd;
    end
  endtask

  // Runs with reqs low; walks the optional clear sequence until the controller is idle.
  task automatic wait_init();
`ifdef RAM_INIT_CLEAR_EN
    int n = 0;
    for (int k = 0; k < 40 && busy; k++) begin
      @(negedge clk);
      if (!mem_lr_n) begin
        check("init_mar", mem_mar, n);
        check("init_data", mem_data_in, 0);
        check("init_ce", mem_ce_n, 1);
        n++;
      end
      check("init_ready", p0_ready | p1_ready, 0);
    end
    check("init_writes", n, 16);
    check("init_exit", busy, 0);
`endif
  endtask

  // One complete access with cycle-exact checks of accept, strobes and done.
  task automatic access(input int p, input logic we, input logic [3:0] addr,
                        input logic [7:0] wd, input logic [7:0] exp_rd);
    int waits = 0;
    @(posedge clk); #1;
    drive(p, 1'b1, we, addr, wd);
    @(negedge clk);
    while (!rdy(p) && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    check("accept", rdy(p), 1);
    check("idle_busy", busy, 0);
    check("other_ready", rdy(1 - p), 0);
    @(posedge clk); #1;
    drive(p, 1'b0, 1'b0, 4'h0, 8'h00);
    @(negedge clk);
    check("issue_lr_n", mem_lr_n, !we);
    check("issue_ce_n", mem_ce_n, we);
    check("issue_mar", mem_mar, addr);
    if (we) check("issue_din", mem_data_in, wd);
    check("issue_busy", busy, 1);
    check("issue_done", dn(p), 0);
    @(negedge clk);
    check("strobe_release", mem_ce_n & mem_lr_n, 1);
    if (!we) begin
      check("capture_done", dn(p), 0);
      @(negedge clk);
    end
    check("done", dn(p), 1);
    check("done_other", dn(1 - p), 0);
    if (!we) check("rdata", rsp_rdata, exp_rd);
  endtask

  initial begin
    int n;
    int exp_p;
    logic prev_ce_low, prev_lr_low;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_ce_n", mem_ce_n, 1);
    check("rst_lr_n", mem_lr_n, 1);
    check("rst_mar", mem_mar, 0);
    check("rst_din", mem_data_in, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_ready", p0_ready | p1_ready, 0);
    check("rst_done", p0_done | p1_done, 0);
`ifdef RAM_INIT_CLEAR_EN
    check("rst_busy", busy, 1);
`else
    check("rst_busy", busy, 0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_init();

    // Both ports hold write requests; grants must alternate starting with port 0
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b1, 4'h1, 8'h11);
    drive(1, 1'b1, 1'b1, 4'h2, 8'h22);
    n = 0;
    exp_p = 0;
    for (int k = 0; k < 40 && n < 4; k++) begin
      @(negedge clk);
      if (p0_ready | p1_ready) begin
        check("rr_grant", p1_ready, exp_p);
        check("rr_onehot", p0_ready & p1_ready, 0);
        exp_p = 1 - exp_p;
        n++;
      end
    end
    check("rr_count", n, 4);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 4'h0, 8'h00);
    drive(1, 1'b0, 1'b0, 4'h0, 8'h00);
    repeat (3) @(negedge clk);
    check("rr_idle", busy, 0);

    // Write then read on port 0
    access(0, 1'b1, 4'h3, 8'hA5, 8'h00);
    access(0, 1'b0, 4'h3, 8'h00, 8'hA5);

    // Port 1 alone: four reads, each granted
    access(1, 1'b0, 4'h1, 8'h00, 8'h11);
    access(1, 1'b0, 4'h2, 8'h00, 8'h22);
    access(1, 1'b0, 4'h3, 8'h00, 8'hA5);
    access(1, 1'b0, 4'h1, 8'h00, 8'h11);

    // A write leaves the last read data untouched
    access(1, 1'b1, 4'h5, 8'h5A, 8'h00);
    check("rdata_hold", rsp_rdata, 8'h11);

    // Reset while a read is in ISSUE: strobes release immediately, no done
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 4'h3, 8'h00);
    @(negedge clk);
    check("mid_accept", p0_ready, 1);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 4'h0, 8'h00);
    @(negedge clk);
    check("mid_issue_ce", mem_ce_n, 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ce", mem_ce_n, 1);
    check("mid_rst_lr", mem_lr_n, 1);
    check("mid_rst_rdata", rsp_rdata, 0);
    repeat (3) begin
      @(negedge clk);
      check("mid_rst_done", p0_done | p1_done, 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_init();
`ifdef RAM_INIT_CLEAR_EN
    access(0, 1'b0, 4'h9, 8'h00, 8'h00);
    access(0, 1'b0, 4'h3, 8'h00, 8'h00);
`else
    access(0, 1'b0, 4'h3, 8'h00, 8'hA5);
`endif

    // Random traffic: strobe exclusivity and single-cycle pulses
    prev_ce_low = 1'b0;
    prev_lr_low = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      @(posedge clk); #1;
      drive(0, 1'($urandom), 1'($urandom), 4'($urandom), 8'($urandom));
      drive(1, 1'($urandom), 1'($urandom), 4'($urandom), 8'($urandom));
      @(negedge clk);
      check("rnd_excl", mem_ce_n | mem_lr_n, 1);
      check("rnd_ce_pulse", !(!mem_ce_n && prev_ce_low), 1);
      check("rnd_lr_pulse", !(!mem_lr_n && prev_lr_low), 1);
      check("rnd_strobe_busy", (mem_ce_n & mem_lr_n) | busy, 1);
      check("rnd_ready_onehot", p0_ready & p1_ready, 0);
      prev_ce_low = !mem_ce_n;
      prev_lr_low = !mem_lr_n;
    end
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 4'h0, 8'h00);
    drive(1, 1'b0, 1'b0, 4'h0, 8'h00);
    repeat (5) @(negedge clk);
    check("final_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
